// File: rtl/muxn_rr_reg.sv
// M-input registered channel selector, fixed-select or round-robin, valid/ready on both sides.
// One cycle from input transfer to out_valid; a stalled output holds its beat and drops every in_ready.
module muxn_rr_reg #(
  parameter int N = 32,
  parameter int M = 4,
  localparam int SELW = $clog2(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [M*N-1:0]  in_data,
  input  logic [M-1:0]    in_valid,
  output logic [M-1:0]    in_ready,
  output logic [N-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] next_ptr;
  logic [M-1:0]    grant;
  logic [SELW-1:0] gidx;
  logic [N-1:0]    gdata;
  logic            load_en;
  logic            in_xfer;
  logic            found;
  int              j;

  assign load_en = !out_valid || out_ready;

  // Round-robin search walks ptr, ptr+1, ... and wraps at M, so it never touches
  // indices >= M even when M is not a power of two.
  always_comb begin
    grant = '0;
    found = 1'b0;
    j     = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < M) grant[sel] = in_valid[sel];
    end else begin
      for (int k = 0; k < M; k++) begin
        j = int'(ptr) + k;
        if (j >= M) j = j - M;
        if (!found && in_valid[j]) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gidx  = '0;
    gdata = '0;
    for (int i = 0; i < M; i++) begin
      if (grant[i]) begin
        gidx  = SELW'(i);
        gdata = in_data[i*N +: N];
      end
    end
  end

  assign next_ptr = (gidx == SELW'(M-1)) ? '0 : gidx + 1'b1;
  assign in_ready = grant & {M{load_en && !reset}};
  assign in_xfer  = |in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= in_xfer;
      if (in_xfer) begin
        out_data <= gdata;
        out_chan <= gidx;
        if (mode) ptr <= next_ptr;
      end
    end
  end

endmodule
